acumulador_somador: RTL
=======================

// Module: acumulador_somador
// PURPOSE
//   Sequential accumulator/controller directly upstream and downstream of the 4-bit
//   two's-complement adder-subtractor (inputs a, B, sub; outputs s, ov).
//   Accepts one command per handshake, drives the accumulator and the operand into the
//   adder-subtractor, and captures s/ov into the accumulator.
//   Presents the result with a valid/ready handshake.
//   Optional saturation; sticky overflow flag.
// PARAMETERS
//   WIDTH     4  data width; must equal the adder-subtractor width (fixed 4)
//   SATURATE  0  1: clamp to +7/-8 on overflow; 0: keep wrapped result
// PORTS
//   clk        in   1      single clock, rising edge
//   reset      in   1      asynchronous, active-high
//   in_valid   in   1      command present
//   in_ready   out  1      block can accept a command
//   in_op      in   2      00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
//   in_data    in   WIDTH  operand (two's complement)
//   add_a      out  WIDTH  to adder a: accumulator value
//   add_b      out  WIDTH  to adder B: latched operand
//   add_sub    out  1      to adder sub: 1 when latched op is SUB
//   add_s      in   WIDTH  from adder s
//   add_ov     in   1      from adder ov
//   acc        out  WIDTH  accumulator register
//   ov_sticky  out  1      set on any ADD/SUB overflow, cleared only by CLEAR/reset
//   out_valid  out  1      result (acc, last_ov) valid
//   out_ready  in   1      consumer accepts result
//   last_ov    out  1      overflow of the most recent command (0 for LOAD/CLEAR)
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, acc=0, op/data latches=0,
//     ov_sticky=0, last_ov=0, out_valid=0, in_ready=1; add_sub=0.
//   FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: in_ready=1. in_valid&in_ready at an edge latches in_op/in_data; go to EXEC.
//   EXEC (exactly 1 cycle, in_ready=0):
//     - add_a=acc, add_b=data_q, add_sub=(op_q==SUB).
//     - Adder path is combinational; add_s/add_ov are sampled at the end of the EXEC cycle.
//     - ADD/SUB: last_ov<=add_ov; ov_sticky|=add_ov.
//       acc<=add_s unless SATURATE&add_ov, then acc<=add_s[3] ? 4'b0111 : 4'b1000.
//     - LOAD: acc<=data_q, last_ov<=0. CLEAR: acc<=0, last_ov<=0, ov_sticky<=0.
//   RESP: out_valid=1, in_ready=0; acc/last_ov held stable.
//     out_valid&out_ready at an edge -> IDLE.
//   Outside EXEC, add_a/add_b still show acc/data_q; add_sub=0.
//     The adder outputs are ignored.
//   Latency: command accept -> out_valid = 2 edges. Max throughput: 1 cmd per 3 cycles.
//   in_valid while in_ready=0 is ignored; the upstream holds the command (no drop, no queue).
//   out_ready is ignored when out_valid=0.
//   out_ready may be held high: RESP then lasts 1 cycle.
//   Wrap-around: with SATURATE=0, acc wraps modulo 16 (e.g. 0111+0001=1000, ov=1).
//   Reset mid-EXEC/RESP aborts the command; acc returns to 0; nothing is reported.
// TESTING
//   1. reset pulse mid-idle -> acc=0, ov_sticky=0, in_ready=1, out_valid=0 while reset high
//   2. LOAD 0101, ADD 0011, SATURATE=0 -> acc=1000, last_ov=1, ov_sticky=1
//      SATURATE=1 -> acc=0111, last_ov=1
//   3. LOAD 0010, SUB 0101 -> add_sub=1 in EXEC, acc=1101 (-3), last_ov=0
//   4. LOAD 1000, SUB 0001, SATURATE=1 -> acc=1000, last_ov=1
//      then CLEAR -> acc=0, ov_sticky=0
//   5. out_ready low 5 cycles in RESP -> out_valid/acc stable, in_ready=0
//      in_valid pulses ignored; accept occurs only after out_ready
//   6. reset asserted during EXEC of ADD 0001 on acc=0110 -> acc=0, state IDLE
//      no out_valid pulse

Source files
------------

// File: rtl/acumulador_somador_if.sv
// rtl/acumulador_somador_if.sv - command, adder and response signals of the accumulator
interface acumulador_somador_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_sub;
    logic [WIDTH-1:0] add_s;
    logic             add_ov;
    logic [WIDTH-1:0] acc;
    logic             ov_sticky;
    logic             out_valid;
    logic             out_ready;
    logic             last_ov;

    modport master (
        output in_valid, in_op, in_data, add_s, add_ov, out_ready,
        input  in_ready, add_a, add_b, add_sub, acc, ov_sticky, out_valid, last_ov
    );

    modport slave (
        input  in_valid, in_op, in_data, add_s, add_ov, out_ready,
        output in_ready, add_a, add_b, add_sub, acc, ov_sticky, out_valid, last_ov
    );
endinterface

// File: rtl/acumulador_somador.sv
// rtl/acumulador_somador.sv - accumulator/controller around an external 4-bit adder-subtractor
module acumulador_somador #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    acumulador_somador_if.slave       bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             sticky_q, sticky_d;
    logic             last_ov_q, last_ov_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            data_q    <= '0;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            last_ov_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
            last_ov_q <= last_ov_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        last_ov_d = last_ov_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = op_t'(bus.in_op);
                    data_d  = bus.in_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
                unique case (op_q)
                    OP_ADD, OP_SUB: begin
                        last_ov_d = bus.add_ov;
                        sticky_d  = sticky_q | bus.add_ov;
                        // A wrapped sum has the wrong sign, so its MSB points to the opposite clamp.
                        if (SATURATE && bus.add_ov) begin
                            acc_d = bus.add_s[WIDTH-1] ? SAT_MAX : SAT_MIN;
                        end else begin
                            acc_d = bus.add_s;
                        end
                    end
                    OP_LOAD: begin
                        acc_d     = data_q;
                        last_ov_d = 1'b0;
                    end
                    OP_CLEAR: begin
                        acc_d     = '0;
                        last_ov_d = 1'b0;
                        sticky_d  = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_RESP: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_RESP);
    assign bus.add_a     = acc_q;
    assign bus.add_b     = data_q;
    assign bus.add_sub   = (state_q == S_EXEC) && (op_q == OP_SUB);
    assign bus.acc       = acc_q;
    assign bus.ov_sticky = sticky_q;
    assign bus.last_ov   = last_ov_q;
endmodule
